dnn_relu_ulaw: RTL and testbench

DNN_RELU_ULAW -- requirements
Module: dnn_relu_ulaw

---
 rtl/dnn_relu_ulaw.sv | 135 +++++++++++++
 tb/tb_dnn_relu_ulaw.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/dnn_relu_ulaw.sv
// dnn_relu_ulaw: two-layer mu-law MLP (401->25 ReLU->10); `define DNN_RELU_ULAW_SATURATE_EN clamps h and layer-2 values instead of wrapping
module dnn_relu_ulaw #(
  parameter int ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE_A = 16'h0000,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE_W = 16'h0191,
  parameter int SM1_SCALE = 4,
  parameter int SD1_SCALE = 2,
  parameter int SM2_SCALE = 16,
  parameter logic [13:0] L2_ONE_BIAS_VAL = 14'h1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  reset,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic signed [7:0]     mem_data,
  output logic signed [7:0]     out [9:0]
);
  localparam logic signed [47:0] L_SM1 = 48'(SM1_SCALE);
  localparam logic signed [47:0] L_SM2 = 48'(SM2_SCALE);
  localparam int L_SH1 = 12 + $clog2(SD1_SCALE);

  typedef enum logic [2:0] {IDLE, L1_A, L1_W, L1_FIN, L2_MAC, L2_FIN, DONE} state_t;

  state_t              r_state, w_next;
  logic [8:0]          r_i;
  logic [4:0]          r_j, r_m;
  logic [3:0]          r_k;
  logic signed [13:0]  r_a, w_dec;
  logic signed [14:0]  w_mul_a;
  logic signed [28:0]  w_prod;
  logic signed [39:0]  r_acc;
  logic signed [47:0]  w_s1, w_s2, w_v2;
  logic [13:0]         w_h;
  logic [13:0]         r_h [25];
  logic signed [7:0]   r_out [9:0];

  function automatic logic signed [13:0] dec(input logic [7:0] c);
    logic [7:0]  t;
    logic [12:0] mag;
    t = ~c;
    mag = ((13'({t[3:0], 1'b1}) + 13'd32) << t[6:4]) - 13'd33;
    return t[7] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  endfunction

  function automatic logic [7:0] enc(input logic signed [47:0] v);
    logic [47:0] a;
    logic [12:0] b;
    logic [2:0]  ch;
    a = v[47] ? -v : v;
    b = 13'(a > 48'd8158 ? 48'd8158 : a) + 13'd33;
    ch = b[12] ? 3'd7 : b[11] ? 3'd6 : b[10] ? 3'd5 : b[9] ? 3'd4 :
         b[8] ? 3'd3 : b[7] ? 3'd2 : b[6] ? 3'd1 : 3'd0;
    return ~{v[47], ch, 4'((b >> ch) >> 1)};
  endfunction

  always_comb begin
    w_dec = dec(mem_data);
    w_mul_a = r_state != L2_MAC ? {r_a[13], r_a} :
              r_m == 5'd0 ? {1'b0, L2_ONE_BIAS_VAL} : {1'b0, r_h[r_m - 5'd1]};
    w_prod = 29'(w_mul_a) * 29'(w_dec);
    w_s1 = (48'(r_acc) * L_SM1) >>> L_SH1;
    w_s2 = (48'(r_acc) * L_SM2) >>> 12;
`ifdef DNN_RELU_ULAW_SATURATE_EN
    w_h = w_s1[47] ? 14'd0 : w_s1 > 48'sd8158 ? 14'd8158 : w_s1[13:0];
    w_v2 = w_s2;
`else
    w_h = 14'(w_s1 & {48{~w_s1[47]}});
    w_v2 = (w_s2 <<< 34) >>> 34;
`endif
  end

  always_comb begin
    mem_addr = r_state == L1_A ? ADDR_WIDTH'(ADDR_BASE_A + r_i) :
               r_state == L1_W ? ADDR_WIDTH'(ADDR_BASE_W + 401 * r_j + r_i) :
               r_state == L2_MAC ? ADDR_WIDTH'(ADDR_BASE_W + 10025 + 26 * r_k + r_m) :
               ADDR_BASE_A;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? L1_A : IDLE;
      L1_A:    w_next = L1_W;
      L1_W:    w_next = r_i == 9'd400 ? L1_FIN : L1_A;
      L1_FIN:  w_next = r_j == 5'd24 ? L2_MAC : L1_A;
      L2_MAC:  w_next = r_m == 5'd25 ? L2_FIN : L2_MAC;
      L2_FIN:  w_next = r_k == 4'd9 ? DONE : L2_MAC;
      default: w_next = r_state;
    endcase
  end

  always_ff @(posedge clk) r_state <= (rst | reset) ? IDLE : w_next;

  // Counters wrap to zero at the end of each loop, so DONE leaves them ready for the next run
  always_ff @(posedge clk) begin
    if (rst | reset) begin
      r_i <= '0;
      r_j <= '0;
      r_m <= '0;
      r_k <= '0;
      r_a <= '0;
      r_acc <= '0;
      for (int n = 0; n < 25; n++) r_h[n] <= '0;
      for (int n = 0; n < 10; n++) r_out[n] <= 8'hFF;
    end else begin
      case (r_state)
        L1_A: r_a <= w_dec;
        L1_W: begin
          r_acc <= r_acc + 40'(w_prod);
          r_i <= r_i == 9'd400 ? 9'd0 : r_i + 9'd1;
        end
        L1_FIN: begin
          r_h[r_j] <= w_h;
          r_acc <= '0;
          r_j <= r_j == 5'd24 ? 5'd0 : r_j + 5'd1;
        end
        L2_MAC: begin
          r_acc <= r_acc + 40'(w_prod);
          r_m <= r_m == 5'd25 ? 5'd0 : r_m + 5'd1;
        end
        L2_FIN: begin
          r_out[r_k] <= enc(w_v2);
          r_acc <= '0;
          r_k <= r_k == 4'd9 ? 4'd0 : r_k + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign done = r_state == DONE;
  assign out = r_out;
endmodule

// File: tb/tb_dnn_relu_ulaw.sv
// tb_dnn_relu_ulaw: table vectors, timing/abort sequences and a random run against an arithmetic model
module tb_dnn_relu_ulaw;
  localparam int BA = 0;
  localparam int BW = 'h191;
  localparam int B2 = BW + 10025;
  localparam int MEMN = B2 + 260;
  localparam int LAT = 20345;

  logic clk = 0, rst = 1, start = 0, reset = 0;
  logic done;
  logic [15:0] mem_addr;
  logic signed [7:0] mem_data;
  logic signed [7:0] out [9:0];
  logic [7:0] mem [MEMN];
  logic [7:0] exp_out [10];
  int errors = 0, checks = 0, lat;

  typedef struct {int k; logic [7:0] code; logic [7:0] exp;} vec_t;
  vec_t tbl [10];

  dnn_relu_ulaw dut (
    .clk(clk), .rst(rst), .start(start), .reset(reset), .done(done),
    .mem_addr(mem_addr), .mem_data(mem_data), .out(out)
  );

  assign mem_data = mem[mem_addr];
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_outs(input string nm);
    for (int k = 0; k < 10; k++)
      check($sformatf("%s out[%0d]", nm, k), {24'd0, $unsigned(out[k])}, {24'd0, exp_out[k]});
  endtask

  task automatic run(input int inj, output int n);
    start = 1;
    tick();
    start = 0;
    for (n = 1; n <= LAT + 100; n++) begin
      start = (n == inj);
      tick();
      if (done) break;
    end
    start = 0;
  endtask

  function automatic longint dec_m(input logic [7:0] c);
    logic [7:0] t;
    longint mag;
    t = ~c;
    mag = ((2 * longint'(t[3:0]) + 33) << t[6:4]) - 33;
    return t[7] ? -mag : mag;
  endfunction

  function automatic logic [7:0] enc_m(input longint v);
    longint a, b;
    int ch;
    a = v < 0 ? -v : v;
    if (a > 8158) a = 8158;
    b = a + 33;
    ch = 0;
    while ((b >> (ch + 6)) != 0) ch++;
    return ~{v < 0, 3'(ch), 4'((b >> (ch + 1)) & 15)};
  endfunction

  function automatic void model();
    longint acc, s;
    longint h [25];
    for (int j = 0; j < 25; j++) begin
      acc = 0;
      for (int i = 0; i < 401; i++) acc += dec_m(mem[BA + i]) * dec_m(mem[BW + 401 * j + i]);
      s = (acc * 4) >>> 13;
`ifdef DNN_RELU_ULAW_SATURATE_EN
      h[j] = s < 0 ? 0 : (s > 8158 ? 8158 : s);
`else
      h[j] = s < 0 ? 0 : (s & 16383);
`endif
    end
    for (int k = 0; k < 10; k++) begin
      acc = dec_m(mem[B2 + 26 * k]) * 4096;
      for (int j = 0; j < 25; j++) acc += h[j] * dec_m(mem[B2 + 26 * k + j + 1]);
      s = (acc * 16) >>> 12;
`ifndef DNN_RELU_ULAW_SATURATE_EN
      s = s & 16383;
      if (s >= 8192) s -= 16384;
`endif
      exp_out[k] = enc_m(s);
    end
  endfunction

  initial begin
    tbl = '{'{0, 8'hFF, 8'hFF}, '{1, 8'hFE, 8'hEF}, '{2, 8'h7E, 8'h6F}, '{3, 8'hF0, 8'hBF},
            '{4, 8'hBF, 8'h80}, '{5, 8'h70, 8'h3F}, '{6, 8'h3F, 8'h00}, '{7, 8'hEF, 8'hBE},
            '{8, 8'hDF, 8'hA6}, '{9, 8'hCF, 8'h92}};
    for (int a = 0; a < MEMN; a++) mem[a] = 8'hFF;
    for (int k = 0; k < 10; k++) exp_out[k] = 8'hFF;
    tick();
    tick();
    rst = 0;
    check("rst done", 32'(done), 0);
    check("rst mem_addr", 32'(mem_addr), 0);
    check_outs("rst");
    model();
    run(1000, lat);
    check("all-FF latency", lat, LAT);
    check("all-FF done", 32'(done), 1);
    check_outs("all-FF");
    start = 1;
    tick();
    start = 0;
    tick();
    tick();
    check("start in DONE done", 32'(done), 1);
    check("DONE mem_addr", 32'(mem_addr), 0);
    check_outs("DONE hold");
    rst = 1;
    reset = 1;
    tick();
    rst = 0;
    reset = 0;
    check("rst+reset done", 32'(done), 0);
    check_outs("rst+reset");
    for (int n = 0; n < 10; n++) mem[B2 + 26 * tbl[n].k] = tbl[n].code;
    run(0, lat);
    check("table latency", lat, LAT);
    for (int n = 0; n < 10; n++)
      check($sformatf("table k=%0d code=%h", tbl[n].k, tbl[n].code),
            {24'd0, $unsigned(out[tbl[n].k])}, {24'd0, tbl[n].exp});
    reset = 1;
    tick();
    reset = 0;
    check("soft reset done", 32'(done), 0);
    for (int a = 0; a < MEMN; a++) mem[a] = ~{1'($urandom), 3'($urandom_range(0, 2)), 4'($urandom)};
    start = 1;
    tick();
    start = 0;
    repeat (4999) tick();
    reset = 1;
    tick();
    reset = 0;
    check("abort done", 32'(done), 0);
    check("abort mem_addr", 32'(mem_addr), 0);
    for (int k = 0; k < 10; k++) check($sformatf("abort out[%0d]", k), {24'd0, $unsigned(out[k])}, 32'hFF);
    model();
    run(0, lat);
    check("random latency", lat, LAT);
    check("random done", 32'(done), 1);
    check_outs("random");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
